// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls and flushes the five-stage pipe for
// multi-cycle multiply/divide, memory wait states, taken branches, load-use and halt.
module hazard_ctrl #(
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_id,
    input  logic [15:0] inst_ex,
    input  logic [15:0] inst_m,
    input  logic        branch_taken,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exm_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exm_flush,
    output logic        mwb_flush,
    output logic        halted,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {RUN, MULDIV, HALT} state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exm_en;
        logic ifid_flush;
        logic idex_flush;
        logic exm_flush;
        logic mwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exm_en: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exm_flush: 1'b0,
                                       mwb_flush: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0,
                                       ifid_flush: 1'b1, idex_flush: 1'b1, exm_flush: 1'b1,
                                       mwb_flush: 1'b1};

    localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 2);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 2);
    localparam logic [7:0] MCNT_LAST = 8'(MEM_TIMEOUT - 1);

    function automatic logic is_mem(input logic [15:0] i);
        return (i[15:13] == 3'b101) || (i[15:13] == 3'b110);
    endfunction

    function automatic logic is_load(input logic [15:0] i);
        return (i[15:12] == 4'b1100) || (i[15:12] == 4'b1010);
    endfunction

    function automatic logic is_mul(input logic [15:0] i);
        return (i[15:12] == 4'b1111) && (i[3:0] == 4'b0100);
    endfunction

    function automatic logic is_div(input logic [15:0] i);
        return (i[15:12] == 4'b1111) && (i[3:0] == 4'b0101);
    endfunction

    // op1 readers: 1111, 10xx (100x/101x), 110x, 010x, 0110
    function automatic logic reads_op1(input logic [3:0] op);
        return (op == 4'b1111) || (op[3:2] == 2'b10) || (op[3:1] == 3'b110) ||
               (op[3:1] == 3'b010) || (op == 4'b0110);
    endfunction

    function automatic logic reads_op2(input logic [3:0] op);
        return (op == 4'b1111) || (op[3:1] == 3'b101) || (op[3:1] == 3'b110);
    endfunction

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] mcnt, mcnt_nx;
    logic       to_flag, to_nx;

    logic       mem_stall;
    logic       md_ex;
    logic       load_use;
    logic       md_busy;
    ctrl_t      ctrl;

    logic       unused_ok;
    assign unused_ok = &{1'b0, inst_m[11:0], inst_id[3:0]};

    assign mem_stall = is_mem(inst_m) && !dmem_ready;
    assign md_ex     = is_mul(inst_ex) || is_div(inst_ex);
    assign load_use  = is_load(inst_ex) &&
                       ((reads_op1(inst_id[15:12]) && (inst_id[11:8] == inst_ex[11:8])) ||
                        (reads_op2(inst_id[15:12]) && (inst_id[7:4]  == inst_ex[11:8])));

    // EX is held by a multiply/divide on its start cycle and while cnt is still counting
    assign md_busy   = ((state == RUN) && md_ex) || ((state == MULDIV) && (cnt != 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= 4'd0;
            mcnt    <= 8'd0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mcnt    <= mcnt_nx;
            to_flag <= to_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mcnt_nx  = 8'd0;
        to_nx    = to_flag;
        if (state == HALT) begin
            state_nx = HALT;
        end else if (mem_stall) begin
            mcnt_nx = mcnt + 8'd1;
            if (mcnt == MCNT_LAST) begin
                state_nx = HALT;
                to_nx    = 1'b1;
            end
        end else if (state == MULDIV) begin
            if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
            else state_nx = RUN;
        end else if (md_ex) begin
            cnt_nx   = is_mul(inst_ex) ? MUL_LOAD : DIV_LOAD;
            state_nx = MULDIV;
        end else if (!branch_taken && !load_use && (inst_id == 16'h000F)) begin
            state_nx = HALT;
        end
    end

    always_comb begin
        ctrl = CTRL_DEFAULT;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (state == HALT) begin
            // upstream frozen and bubbled; EX/MEM/WB keep draining
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (mem_stall) begin
            ctrl.pc_en     = 1'b0;
            ctrl.ifid_en   = 1'b0;
            ctrl.idex_en   = 1'b0;
            ctrl.exm_en    = 1'b0;
            ctrl.mwb_flush = 1'b1;
        end else if (md_busy) begin
            ctrl.pc_en     = 1'b0;
            ctrl.ifid_en   = 1'b0;
            ctrl.idex_en   = 1'b0;
            ctrl.exm_flush = 1'b1;
        end else if (state == MULDIV) begin
            ctrl = CTRL_DEFAULT;
        end else if (branch_taken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exm_en      = ctrl.exm_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exm_flush   = ctrl.exm_flush;
    assign mwb_flush   = ctrl.mwb_flush;
    assign halted      = !rst && (state == HALT);
    assign mem_timeout = to_flag;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an occupancy-based model.
module tb_hazard_ctrl;

    localparam int MULC = 4;
    localparam int DIVC = 8;
    localparam int MTO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst_id = '0, inst_ex = '0, inst_m = '0;
    logic        branch_taken = 1'b0, dmem_ready = 1'b1;
    logic        pc_en, ifid_en, idex_en, exm_en;
    logic        ifid_flush, idex_flush, exm_flush, mwb_flush, halted, mem_timeout;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .MEM_TIMEOUT(MTO)) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_ex(inst_ex), .inst_m(inst_m),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exm_flush(exm_flush),
        .mwb_flush(mwb_flush), .halted(halted), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Model state: halted, sticky timeout, EX occupancy progress, memory stall streak
    bit m_halt = 0, m_to = 0, m_busy = 0;
    int m_elapsed = 0, m_total = 0, m_streak = 0;

    function automatic bit f_mem(input logic [15:0] i);
        return i[15:12] inside {4'hA, 4'hB, 4'hC, 4'hD};
    endfunction
    function automatic bit f_md(input logic [15:0] i);
        return i[15:12] == 4'hF && (i[3:0] == 4'h4 || i[3:0] == 4'h5);
    endfunction
    function automatic bit f_lu(input logic [15:0] ex, input logic [15:0] id);
        bit r1, r2;
        r1 = id[15:12] inside {4'hF, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h4, 4'h5, 4'h6};
        r2 = id[15:12] inside {4'hF, 4'hA, 4'hB, 4'hC, 4'hD};
        return (ex[15:12] == 4'hC || ex[15:12] == 4'hA) &&
               ((r1 && id[11:8] == ex[11:8]) || (r2 && id[7:4] == ex[11:8]));
    endfunction

    // {pc,ifid,idex,exm en, ifid,idex,exm,mwb flush, halted, mem_timeout}
    function automatic logic [9:0] model_out();
        logic [3:0] en, fl;
        bit ms;
        if (rst) return 10'b0000_1111_00;
        en = 4'b1111; fl = 4'b0000;
        ms = f_mem(inst_m) && !dmem_ready;
        if (m_halt) begin
            en[3] = 0; en[2] = 0; fl[3] = 1; fl[2] = 1;
        end else if (ms) begin
            en = 4'b0000; fl[0] = 1;
        end else if ((m_busy && m_elapsed < m_total - 1) || (!m_busy && f_md(inst_ex))) begin
            en = 4'b0001; fl[1] = 1;
        end else if (m_busy) begin
            en = 4'b1111;
        end else if (branch_taken) begin
            fl[3] = 1; fl[2] = 1;
        end else if (f_lu(inst_ex, inst_id)) begin
            en[3] = 0; en[2] = 0; fl[2] = 1;
        end
        return {en, fl, m_halt, m_to};
    endfunction

    task automatic model_step();
        bit ms;
        ms = f_mem(inst_m) && !dmem_ready;
        if (rst) begin
            m_halt = 0; m_to = 0; m_busy = 0; m_elapsed = 0; m_streak = 0;
        end else if (m_halt) begin
        end else if (ms) begin
            m_streak++;
            if (m_streak == MTO) begin m_halt = 1; m_to = 1; end
        end else begin
            m_streak = 0;
            if (m_busy) begin
                if (m_elapsed < m_total - 1) m_elapsed++;
                else m_busy = 0;
            end else if (f_md(inst_ex)) begin
                m_busy = 1; m_elapsed = 1;
                m_total = (inst_ex[3:0] == 4'h4) ? MULC : DIVC;
            end else if (!branch_taken && !f_lu(inst_ex, inst_id) && inst_id == 16'h000F) begin
                m_halt = 1;
            end
        end
    endtask

    initial forever begin
        logic [9:0] exp_v, act_v;
        @(negedge clk);
        exp_v = model_out();
        act_v = {pc_en, ifid_en, idex_en, exm_en, ifid_flush, idex_flush, exm_flush,
                 mwb_flush, halted, mem_timeout};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%b exp=%b (pc,ifid,idex,exm en|ifid,idex,exm,mwb fl|halt,to)",
                     $time, act_v, exp_v);
        end
        model_step();
    end

    task automatic chk(input string name, input logic act, input logic exp_b);
        checks++;
        if (act !== exp_b) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp_b);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        inst_id = '0; inst_ex = '0; inst_m = '0; branch_taken = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1; #1;
        chk("rst_halted", halted, 1'b0);
        chk("rst_timeout", mem_timeout, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_mwb_flush", mwb_flush, 1'b1);
        tick(); idle(); rst = 0;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [15:0] r;
        r = 16'($urandom);
        r[11:8] = 4'($urandom_range(0, 3));
        r[7:4]  = 4'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0: r = {4'hF, r[11:4], 4'h4};
            1: r = {4'hF, r[11:4], 4'h5};
            2, 3: r[15:12] = ($urandom_range(0, 1) != 0) ? 4'hC : 4'hA;
            4: if ($urandom_range(0, 7) == 0) r = 16'h000F;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int stalls;
        tick(); do_reset();

        // load-use: one bubble, then cleared by the NOP in EX
        inst_ex = 16'hC310; inst_id = 16'hF230; #2;
        chk("lu_pc_en", pc_en, 1'b0);
        chk("lu_ifid_en", ifid_en, 1'b0);
        chk("lu_idex_flush", idex_flush, 1'b1);
        tick(); inst_ex = 16'h0000; #2;
        chk("lu_cleared", pc_en, 1'b1);
        inst_ex = 16'hC310; inst_id = 16'h8210; #2;
        chk("lu_op1_only", pc_en, 1'b1);
        tick(); idle();

        // multiply then divide occupancy
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? MULC : DIVC;
            inst_ex = (k == 0) ? 16'hF124 : 16'hF125;
            stalls = 0;
            for (int i = 0; i < n; i++) begin
                #2; if (pc_en == 0) stalls++;
                if (i == n - 1) chk("md_last_default", exm_flush, 1'b0);
                tick();
            end
            inst_ex = '0;
            checks++;
            if (stalls != n - 1) begin
                failures++;
                $display("FAIL md_stall_cycles got=%0d exp=%0d", stalls, n - 1);
            end
        end

        // memory stall in the middle of a multiply
        inst_ex = 16'hF124;
        for (int i = 0; i < 7; i++) begin
            inst_m = (i >= 1 && i <= 3) ? 16'hC000 : 16'h0000;
            dmem_ready = !(i >= 1 && i <= 3);
            #2;
            chk("mdm_pc_en", pc_en, (i == 6));
            chk("mdm_mwb_flush", mwb_flush, (i >= 1 && i <= 3));
            tick();
        end
        idle();

        // branch suppresses halt detect
        inst_ex = 16'h4120; inst_id = 16'h000F; branch_taken = 1; #2;
        chk("br_pc_en", pc_en, 1'b1);
        chk("br_ifid_flush", ifid_flush, 1'b1);
        chk("br_idex_flush", idex_flush, 1'b1);
        tick(); idle(); #2;
        chk("br_no_halt", halted, 1'b0);

        // halt
        inst_id = 16'h000F; tick(); idle(); #2;
        chk("halt_halted", halted, 1'b1);
        chk("halt_pc_en", pc_en, 1'b0);
        chk("halt_ifid_flush", ifid_flush, 1'b1);
        chk("halt_idex_flush", idex_flush, 1'b1);
        tick(); tick(); #2;
        chk("halt_persist", halted, 1'b1);
        chk("halt_no_timeout", mem_timeout, 1'b0);
        do_reset();

        // memory timeout
        inst_m = 16'hD000; dmem_ready = 0;
        for (int i = 0; i < MTO; i++) begin
            #2; chk("to_not_yet", halted, 1'b0); tick();
        end
        #2;
        chk("to_halted", halted, 1'b1);
        chk("to_flag", mem_timeout, 1'b1);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 80) == 0) begin
                rst = 1; tick(); rst = 0;
            end
            inst_id = rand_inst(); inst_ex = rand_inst();
            inst_m = ($urandom_range(0, 9) < 4) ? {4'hA + 4'($urandom_range(0, 3)), 12'h000}
                                                 : rand_inst();
            branch_taken = ($urandom_range(0, 4) == 0);
            dmem_ready = ($urandom_range(0, 4) != 0);
            tick();
        end

        idle(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, EX occupancy in cycles of a multiply (legal range 2-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 8, EX occupancy in cycles of a divide (legal range 2-15).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, maximum number of consecutive memory-stall cycles before halting (legal range 1-255).
REQ-004 SHALL have the following ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- inst_id  in  16  instruction in ID.
- inst_ex  in  16  instruction in EX.
- inst_m  in  16  instruction in MEM.
- branch_taken  in  1  branch in EX resolved taken.
- dmem_ready  in  1  data memory has completed the MEM-stage access.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exm_en  out  1 each  pipeline register load enables.
- ifid_flush, idex_flush, exm_flush, mwb_flush  out  1 each  load NOP (16'h0000) into the register; flush overrides en.
- halted  out  1  core halted.
- mem_timeout  out  1  sticky flag: halted because of a memory timeout.

Function
REQ-005 Encoding: [15:12] opcode, [11:8] op1, [7:4] op2, [3:0] func/imm.
- load = 1100 or 1010; mem op = 101x or 110x.
- multiply = 1111 with func 0100; divide = 1111 with func 0101.
- halt = 16'h000F.
REQ-006 ID reads op1 when its opcode is 1111, 101x, 110x, 100x, 010x or 0110; ID reads op2 when its opcode is 1111, 101x or 110x.
REQ-007 Registered state:
- FSM: RUN, MULDIV, HALT.
- cnt: 4-bit multiply/divide counter.
- mcnt: 8-bit memory-stall counter.
- mem_timeout flag.
REQ-008 Default outputs, applied when no rule below fires: all enables 1, all flushes 0.
REQ-009 Rules are evaluated in this priority order: HALT, mem_stall, MULDIV/muldiv start, branch, load-use, halt detect.
REQ-010 HALT state:
- pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1.
- Downstream stages keep draining; halted=1.
- HALT is left only by reset.
REQ-011 mem_stall = (inst_m is a mem op) AND NOT dmem_ready.
REQ-012 While mem_stall:
- pc_en, ifid_en, idex_en and exm_en are 0; mwb_flush=1.
- FSM state and cnt hold.
- mcnt increments.
REQ-013 Any cycle without mem_stall clears mcnt to 0.
REQ-014 Memory timeout: when mem_stall and mcnt==MEM_TIMEOUT-1, the next edge sets mem_timeout=1 and state=HALT.
REQ-015 Muldiv start: in RUN, when inst_ex is a multiply/divide and there is no mem_stall:
- pc_en, ifid_en and idex_en are 0; exm_flush=1.
- cnt loads (MUL_CYCLES or DIV_CYCLES)-2; state goes to MULDIV.
REQ-016 MULDIV, no mem_stall, cnt!=0: same outputs as muldiv start; cnt decrements.
REQ-017 MULDIV, no mem_stall, cnt==0: default outputs (result passes to MEM, next instruction enters EX); state goes to RUN.
REQ-018 Total EX occupancy of a multiply/divide SHALL be exactly MUL_CYCLES/DIV_CYCLES cycles, excluding mem_stall cycles.
REQ-019 branch_taken SHALL be ignored in MULDIV and during mem_stall.
REQ-020 Branch: in RUN with branch_taken=1: pc_en=1, ifid_flush=1, idex_flush=1.
REQ-021 Branch flush SHALL suppress both load-use and halt detect in the same cycle.
REQ-022 Load-use: in RUN, inst_ex is a load and its op1 equals an ID-read operand (per REQ-006):
- pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle.
- The bubble in EX clears the condition on the next cycle; no extra state.
REQ-023 Halt detect: in RUN, when inst_id==16'h000F and no higher-priority rule fires, the next edge sets state=HALT.
REQ-024 Outputs SHALL be combinational functions of state, cnt, mcnt and the inputs; no output SHALL have added latency.

Reset
REQ-025 While rst=1:
- state=RUN, cnt=0, mcnt=0, mem_timeout=0.
- All enables 0; all flushes 1 (pipeline registers are filled with NOPs); halted=0.
REQ-026 Reset asserted mid-MULDIV, mid-mem_stall or in HALT SHALL take effect immediately, with no pending state surviving.
REQ-027 First edge after rst deasserts: normal operation from RUN.

Verification
REQ-028 Scenario load-use:
- Stimulus: inst_ex=16'hC310, inst_id=16'hF230, branch_taken=0, dmem_ready=1.
- Response: exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1. Swapping inst_id to 16'h8210 (op1 r2 only) produces no stall.
REQ-029 Scenario multiply:
- Stimulus: inst_ex=16'hF124 with MUL_CYCLES=4.
- Response: stall outputs for 3 cycles (cnt 2,1,0 loaded/decremented); 4th cycle default outputs and state=RUN.
- Repeat with func 0101 and DIV_CYCLES=8: 7 stall cycles.
REQ-030 Scenario mem stall during multiply:
- Stimulus: inst_m=16'hC000 with dmem_ready=0 for 3 cycles in the middle of the multiply.
- Response: cnt frozen, mwb_flush=1 and all upstream enables 0 during those cycles; EX occupancy becomes 4+3 cycles.
REQ-031 Scenario branch:
- Stimulus: branch_taken=1 in RUN with inst_ex=16'h4120 and inst_id=16'h000F.
- Response: ifid_flush=idex_flush=1, pc_en=1, no transition to HALT.
REQ-032 Scenario halt:
- Stimulus: inst_id=16'h000F.
- Response: next cycle halted=1, pc_en=0, ifid_flush=1, idex_flush=1, persisting until rst; mem_timeout stays 0.
REQ-033 Scenario timeout:
- Stimulus: MEM_TIMEOUT=4, inst_m=16'hD000, dmem_ready held 0.
- Response: after 4 stall cycles halted=1 and mem_timeout=1; a subsequent rst pulse clears both immediately.
